// File: rtl/lspc_pkg.sv
// Shared constants for the LSPC timer/IRQ block: register word addresses,
// mode-register bit positions and the IPL "nothing pending" code.
package lspc_pkg;

   localparam logic [2:0] ADDR_MODE       = 3'd3;
   localparam logic [2:0] ADDR_RELOAD_MSB = 3'd4;
   localparam logic [2:0] ADDR_RELOAD_LSB = 3'd5;
   localparam logic [2:0] ADDR_IRQ_ACK    = 3'd6;
   localparam logic [2:0] ADDR_STOP       = 3'd7;

   // TMODE bits (after extraction from the mode register)
   localparam int TMODE_LSB_LOAD    = 0;
   localparam int TMODE_VBL_LOAD    = 1;
   localparam int TMODE_AUTO_RELOAD = 2;

   // Position of fields inside the mode register write data
   localparam int MODE_TIRQ_EN_BIT = 4;
   localparam int MODE_TMODE_LSB   = 5;

   // Pending slot owned by the timer
   localparam int TIMER_IRQ_IDX = 1;

   localparam logic [2:0] IPL_NONE = 3'b111;

   typedef logic [2:0] tmode_t;

   // Active-low IPL level for pending source idx (level = idx + 1)
   function automatic logic [2:0] ipl_code(input int idx);
      return ~3'(idx + 1);
   endfunction

endpackage

// File: rtl/lspc_timer_irq_if.sv
// CPU register write port of the LSPC timer/IRQ block.
interface lspc_timer_irq_if;
   logic        WR_EN;
   logic [2:0]  WR_ADDR;
   logic [15:0] WR_DATA;

   modport master (output WR_EN, WR_ADDR, WR_DATA);
   modport slave  (input  WR_EN, WR_ADDR, WR_DATA);
endinterface

// File: rtl/lspc_irq_prio.sv
// Priority encoder: highest pending index wins, reported as active-low IPL.
module lspc_irq_prio
   import lspc_pkg::*;
#(
   parameter int NUM_IRQ = 3
) (
   input  logic [NUM_IRQ-1:0] pend,
   output logic [2:0]         ipl_n
);

   // Scan upward so the last (highest) pending index overrides lower ones
   always_comb begin
      ipl_n = IPL_NONE;
      for (int k = 0; k < NUM_IRQ; k++) begin
         if (pend[k]) ipl_n = ipl_code(k);
      end
   end

endmodule

// File: rtl/lspc_timer_irq.sv
// LSPC raster timer and interrupt controller.
// Down-counting timer clocked by the pixel tick during vblank lines, with
// reload/one-shot modes, CPU and vblank loads, and a small pending/ack IRQ
// block feeding an IPL priority encoder.
// Optional build macro: LSPC_TIMER_PALSTOP_EN -- adds the STOP register that
// freezes the timer on the PAL border lines (VIDEO_MODE=1 only).
module lspc_timer_irq
   import lspc_pkg::*;
#(
   parameter int TIMER_W    = 32,
   parameter int NUM_IRQ    = 3,
   parameter int VIDEO_MODE = 0
) (
   input  logic                CLK_24M,
   input  logic                nRESET,
   input  logic                PIXEL_EN,
   input  logic [8:0]          VCOUNT,
   input  logic                VBL_START,
   lspc_timer_irq_if.slave     bus,
   input  logic [NUM_IRQ-1:0]  IRQ_SRC,
   output logic [NUM_IRQ-1:0]  IRQ_PEND,
   output logic [2:0]          IPL_N,
   output logic [TIMER_W-1:0]  TIMER_VAL
);

   localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);
   localparam logic [NUM_IRQ-1:0] PEND_RESET = {1'b1, {(NUM_IRQ-1){1'b0}}};

   logic [TIMER_W-1:0] timer_q, timer_d, reload_q;
   tmode_t             tmode_q;
   logic               tirq_en_q;
   logic [NUM_IRQ-1:0] pend_q, pend_d, src_mask, ack_mask;
   logic               wr_mode, wr_msb, wr_lsb, wr_ack, wr_stop;
   logic               pal_stop, border_line, run, tick, fire;
   logic               lsb_load, vbl_load;
   logic               unused_vcount_lo;

   assign wr_mode = bus.WR_EN && (bus.WR_ADDR == ADDR_MODE);
   assign wr_msb  = bus.WR_EN && (bus.WR_ADDR == ADDR_RELOAD_MSB);
   assign wr_lsb  = bus.WR_EN && (bus.WR_ADDR == ADDR_RELOAD_LSB);
   assign wr_ack  = bus.WR_EN && (bus.WR_ADDR == ADDR_IRQ_ACK);
   assign wr_stop = bus.WR_EN && (bus.WR_ADDR == ADDR_STOP);

`ifdef LSPC_TIMER_PALSTOP_EN
   logic stop_q;

   // STOP register, only meaningful on PAL builds
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET)      stop_q <= 1'b0;
      else if (wr_stop) stop_q <= bus.WR_DATA[0];
   end

   assign pal_stop = (VIDEO_MODE == 1) && stop_q;
`else
   logic unused_stop;

   assign pal_stop    = 1'b0;
   assign unused_stop = wr_stop ^ (VIDEO_MODE == 1);
`endif

   // PAL border lines are the first and last 16 lines of the vblank half
   assign border_line      = (VCOUNT[7:4] == 4'h0) || (VCOUNT[7:4] == 4'hF);
   assign run              = VCOUNT[8] && !(pal_stop && border_line);
   assign tick             = PIXEL_EN && run;
   assign unused_vcount_lo = ^VCOUNT[3:0];

   assign lsb_load = wr_lsb && tmode_q[TMODE_LSB_LOAD];
   assign vbl_load = VBL_START && tmode_q[TMODE_VBL_LOAD];

   // Next timer value: a CPU LSB load beats a vblank load, and either load
   // replaces the tick entirely (including its interrupt)
   always_comb begin
      timer_d = timer_q;
      fire    = 1'b0;
      if (lsb_load) begin
         timer_d = {reload_q[TIMER_W-1:16], bus.WR_DATA};
      end else if (vbl_load) begin
         timer_d = reload_q;
      end else if (tick) begin
         if (timer_q > T_ONE) begin
            timer_d = timer_q - T_ONE;
         end else if (timer_q == T_ONE) begin
            timer_d = '0;
            fire    = tirq_en_q;
         end else if (tmode_q[TMODE_AUTO_RELOAD]) begin
            timer_d = reload_q;
         end
      end
   end

   // Pending flags: new events set, acks clear, set wins on collision
   always_comb begin
      src_mask                = IRQ_SRC;
      src_mask[TIMER_IRQ_IDX] = fire;
      ack_mask                = wr_ack ? bus.WR_DATA[NUM_IRQ-1:0] : '0;
      pend_d                  = (pend_q & ~ack_mask) | src_mask;
   end

   // Timer, pending and configuration registers
   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         timer_q   <= '0;
         reload_q  <= '0;
         tmode_q   <= '0;
         tirq_en_q <= 1'b0;
         pend_q    <= PEND_RESET;
      end else begin
         timer_q <= timer_d;
         pend_q  <= pend_d;
         if (wr_mode) begin
            tmode_q   <= bus.WR_DATA[MODE_TMODE_LSB +: 3];
            tirq_en_q <= bus.WR_DATA[MODE_TIRQ_EN_BIT];
         end
         if (wr_msb) reload_q[TIMER_W-1:16] <= bus.WR_DATA[TIMER_W-17:0];
         if (wr_lsb) reload_q[15:0]         <= bus.WR_DATA;
      end
   end

   lspc_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .pend  (pend_q),
      .ipl_n (IPL_N)
   );

   assign IRQ_PEND  = pend_q;
   assign TIMER_VAL = timer_q;

endmodule

// File: doc/lspc_timer_irq.md
LSPC_TIMER_IRQ -- requirements
Module: lspc_timer_irq

Interface
REQ-001 SHALL have parameter TIMER_W, default 32, timer and reload width, legal range 17..32.
REQ-002 SHALL have parameter NUM_IRQ, default 3, number of interrupt sources, legal range 2..7.
REQ-003 SHALL have parameter VIDEO_MODE, default 0, 0=NTSC, 1=PAL.
REQ-004 SHALL have port CLK_24M  in  1  master clock, all state on rising edge.
REQ-005 SHALL have port nRESET  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port PIXEL_EN  in  1  one-cycle pixel tick, 1 in 4 clocks.
REQ-007 SHALL have port VCOUNT  in  9  current raster line.
REQ-008 SHALL have port VBL_START  in  1  one-cycle pulse at first vblank line.
REQ-009 SHALL have port WR_EN  in  1  one-cycle register write strobe.
REQ-010 SHALL have port WR_ADDR  in  3  register word address (M68K_ADDR[3:1]).
REQ-011 SHALL have port WR_DATA  in  16  write data.
REQ-012 SHALL have port IRQ_SRC  in  NUM_IRQ  external source pulses; bit 1 is ignored (timer owns it).
REQ-013 SHALL have port IRQ_PEND  out  NUM_IRQ  pending flags.
REQ-014 SHALL have port IPL_N  out  3  active-low level of highest pending source (index+1); 3'b111 when none.
REQ-015 SHALL have port TIMER_VAL  out  TIMER_W  current counter, for debug.

Function
REQ-016 SHALL decode writes: addr 3 = mode (bits 7:5 TMODE, bit 4 TIRQ_EN); 4 = reload MSB (WR_DATA[TIMER_W-17:0] to RELOAD[TIMER_W-1:16]); 5 = reload LSB; 6 = ack (bit k clears pending k); 7 = STOP bit 0; other addresses ignored.
REQ-017 SHALL define RUN = VCOUNT[8] AND NOT (PAL stop active AND VCOUNT[7:4] in {0000,1111}).
REQ-018 SHALL, on PIXEL_EN with RUN and TIMER>1, decrement TIMER by 1.
REQ-019 SHALL, on PIXEL_EN with RUN and TIMER==1, set TIMER to 0 and set pending[1] if TIRQ_EN.
REQ-020 SHALL, on PIXEL_EN with RUN and TIMER==0, load RELOAD if TMODE[2], else hold 0 without re-firing.
REQ-021 SHALL load TIMER from {RELOAD[MSB],WR_DATA} on LSB write when TMODE[0], overriding a same-cycle tick.
REQ-022 SHALL load TIMER from RELOAD on VBL_START when TMODE[1]; LSB write wins if both occur in the same cycle.
REQ-023 SHALL set pending[k] one cycle after IRQ_SRC[k] (k≠1); set wins over same-cycle ack.
REQ-024 SHALL drive IPL_N combinationally from IRQ_PEND: highest index pending wins.
REQ-025 SHALL not change TIMER when PIXEL_EN is low, except through REQ-021/022.

Reset
REQ-026 SHALL on nRESET low set TIMER=0, RELOAD=0, TMODE=0, TIRQ_EN=0, STOP=0, IRQ_PEND=1<<(NUM_IRQ-1) (cold-boot IRQ); IPL_N=~NUM_IRQ.
REQ-027 SHALL abort any count mid-operation on reset with no spurious IRQ after release.

Configuration
REQ-028 SHALL with LSPC_TIMER_PALSTOP_EN defined honour STOP in RUN when VIDEO_MODE=1.
REQ-029 SHALL without LSPC_TIMER_PALSTOP_EN treat PAL stop as 0; addr 7 writes are ignored.

Structure
REQ-030 SHALL place register address constants, TMODE bit positions and IPL "none" code in shared package lspc_pkg.
REQ-031 SHALL implement the priority encoder as sub-module lspc_irq_prio (NUM_IRQ in, IPL_N out).

Verification
REQ-032 Reload=3, TMODE=100, TIRQ_EN=1, VCOUNT=0x110 -> TIMER 3,2,1,0 per tick; pending[1] after 3rd tick; reload on 4th; IPL_N=3'b101.
REQ-033 TMODE=000, TIMER reaches 0 -> single IRQ, TIMER holds 0 for 10 further ticks.
REQ-034 PAL, macro on, STOP=1, VCOUNT=0x100 -> TIMER frozen; VCOUNT=0x110 -> decrements.
REQ-035 IRQ_SRC[0] pulse with ack bit 0 in the same cycle -> pending[0]=1; ack next cycle -> 0.
REQ-036 Reset -> IPL_N=3'b100 (NUM_IRQ=3); ack 0x4 -> IPL_N=3'b111.
REQ-037 TMODE=011, LSB write 0x0010 and VBL_START in the same cycle -> TIMER=RELOAD[MSB]:0x0010.
